// File: rtl/iir_channel_scheduler_if.sv
// Channel-side bundle of the two-channel IIR scheduler: input FIFO read ports,
// output FIFO write ports, history clear and busy status.
interface iir_channel_scheduler_if #(
    parameter int DATA_WIDTH = 32
);
    logic [1:0][DATA_WIDTH-1:0] x_in;
    logic [1:0]                 x_in_empty;
    logic [1:0]                 x_in_rd_en;
    logic [1:0][DATA_WIDTH-1:0] y_out;
    logic [1:0]                 y_out_full;
    logic [1:0]                 y_out_wr_en;
    logic                       hist_clr;
    logic                       busy;

    modport master (
        output x_in, x_in_empty, y_out_full, hist_clr,
        input  x_in_rd_en, y_out, y_out_wr_en, busy
    );

    modport slave (
        input  x_in, x_in_empty, y_out_full, hist_clr,
        output x_in_rd_en, y_out, y_out_wr_en, busy
    );
endinterface

// File: rtl/iir_channel_scheduler.sv
// Two-channel first-order IIR (de-emphasis) sharing one multiplier; round-robin
// arbitration, one sample per five cycles, private history per channel.
module iir_channel_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 10,
    parameter int B0         = 178,
    parameter int B1         = 178,
    parameter int A1         = -666
) (
    input logic                    clock,
    input logic                    reset,
    iir_channel_scheduler_if.slave bus
);
    typedef enum logic [2:0] {
        ARB   = 3'd0,
        MAC0  = 3'd1,
        MAC1  = 3'd2,
        MAC2  = 3'd3,
        WRITE = 3'd4
    } state_t;

    localparam logic [DATA_WIDTH-1:0] B0_C = DATA_WIDTH'(B0);
    localparam logic [DATA_WIDTH-1:0] B1_C = DATA_WIDTH'(B1);
    localparam logic [DATA_WIDTH-1:0] A1_C = DATA_WIDTH'(A1);

    // Full-width signed product, floor shift, then truncate back to DATA_WIDTH.
    function automatic logic [DATA_WIDTH-1:0] mul(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic [2*DATA_WIDTH-1:0] prod;
        prod = {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a} * {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b};
        prod = $unsigned($signed(prod) >>> FRAC_BITS);
        return prod[DATA_WIDTH-1:0];
    endfunction

    state_t                     state_q, state_d;
    logic                       rr_q, rr_d;
    logic                       gsel_q, gsel_d;
    logic [1:0][DATA_WIDTH-1:0] x_prev_q, x_prev_d;
    logic [1:0][DATA_WIDTH-1:0] y_prev_q, y_prev_d;
    logic [1:0][DATA_WIDTH-1:0] y_out_q, y_out_d;
    logic [DATA_WIDTH-1:0]      acc_q, acc_d;
    logic [DATA_WIDTH-1:0]      x_cur_q, x_cur_d;
    logic [1:0]                 wr_en_q, wr_en_d;
    logic                       busy_q, busy_d;
    logic [1:0]                 rd_en_s;
    logic [1:0]                 elig_s;
    logic                       grant_s;

    // Next-state, datapath and output computation for the sample sequencer.
    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        gsel_d   = gsel_q;
        x_prev_d = x_prev_q;
        y_prev_d = y_prev_q;
        y_out_d  = y_out_q;
        acc_d    = acc_q;
        x_cur_d  = x_cur_q;
        wr_en_d  = 2'b00;
        rd_en_s  = 2'b00;
        elig_s   = ~bus.x_in_empty & ~bus.y_out_full;
        grant_s  = 1'b0;

        case (state_q)
            ARB: begin
                if (bus.hist_clr) begin
                    x_prev_d = '0;
                    y_prev_d = '0;
                end else if (elig_s != 2'b00) begin
                    if (elig_s == 2'b11) begin
                        grant_s = rr_q;
                    end else begin
                        grant_s = elig_s[1];
                    end
                    rd_en_s[grant_s] = 1'b1;
                    x_cur_d          = bus.x_in[grant_s];
                    gsel_d           = grant_s;
                    state_d          = MAC0;
                end else begin
                    state_d = ARB;
                end
            end
            MAC0: begin
                acc_d   = mul(x_cur_q, B0_C);
                state_d = MAC1;
            end
            MAC1: begin
                acc_d   = acc_q + mul(x_prev_q[gsel_q], B1_C);
                state_d = MAC2;
            end
            MAC2: begin
                // Result is final here, so the output register and strobe are loaded
                // now and present it during WRITE.
                acc_d            = acc_q + mul(y_prev_q[gsel_q], A1_C);
                y_out_d[gsel_q]  = acc_d;
                wr_en_d[gsel_q]  = 1'b1;
                state_d          = WRITE;
            end
            WRITE: begin
                x_prev_d[gsel_q] = x_cur_q;
                y_prev_d[gsel_q] = acc_q;
                rr_d             = ~gsel_q;
                state_d          = ARB;
            end
            default: begin
                state_d = ARB;
            end
        endcase

        busy_d = (state_d != ARB);
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ARB;
            rr_q     <= 1'b0;
            gsel_q   <= 1'b0;
            x_prev_q <= '0;
            y_prev_q <= '0;
            y_out_q  <= '0;
            acc_q    <= '0;
            x_cur_q  <= '0;
            wr_en_q  <= 2'b00;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            gsel_q   <= gsel_d;
            x_prev_q <= x_prev_d;
            y_prev_q <= y_prev_d;
            y_out_q  <= y_out_d;
            acc_q    <= acc_d;
            x_cur_q  <= x_cur_d;
            wr_en_q  <= wr_en_d;
            busy_q   <= busy_d;
        end
    end

    // The pop strobe must react to FIFO status in the grant cycle, so it is
    // combinational; it is forced low while reset is held.
    assign bus.x_in_rd_en  = rd_en_s & {2{reset}};
    assign bus.y_out_wr_en = wr_en_q;
    assign bus.y_out       = y_out_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_iir_channel_scheduler.sv
// Directed bench for iir_channel_scheduler: FIFO models, a transaction-level
// scheduler/filter model compared every cycle, and hand-computed pins.
module tb_iir_channel_scheduler;
    logic clk;
    logic reset;

    iir_channel_scheduler_if #(.DATA_WIDTH(32)) ifc ();

    iir_channel_scheduler #(
        .DATA_WIDTH(32), .FRAC_BITS(10), .B0(178), .B1(178), .A1(-666)
    ) dut (
        .clock(clk),
        .reset(reset),
        .bus  (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errs   = 0;

    int inq[2][$];
    int wr_log[2][$];
    int grant_log[$];

    // model state: cycles left in the current sample (0 = arbitrating)
    int m_left;
    int m_g, m_rr, m_x, m_y;
    int m_xp[2];
    int m_yp[2];
    int m_yout[2];

    function automatic int fmul(input int a, input int b);
        longint p;
        p = longint'(a) * longint'(b);
        p = p >>> 10;
        return int'(p);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", name, act, act, exp, exp);
        end
    endtask

    function automatic int logv(input int c, input int i);
        if (i < wr_log[c].size()) return wr_log[c][i];
        return 32'h0BAD_0BAD;
    endfunction

    task automatic refresh();
        for (int c = 0; c < 2; c++) begin
            ifc.x_in_empty[c] = (inq[c].size() == 0);
            ifc.x_in[c]       = (inq[c].size() != 0) ? inq[c][0] : 0;
        end
    endtask

    task automatic push(input int c, input int v);
        inq[c].push_back(v);
        refresh();
    endtask

    task automatic model_reset();
        m_left = 0; m_g = 0; m_rr = 0; m_x = 0; m_y = 0;
        for (int c = 0; c < 2; c++) begin
            m_xp[c] = 0; m_yp[c] = 0; m_yout[c] = 0;
        end
    endtask

    task automatic clear_logs();
        for (int c = 0; c < 2; c++) wr_log[c].delete();
        grant_log.delete();
    endtask

    // One clock: evaluate the model and compare at the falling edge, then let
    // the FIFO model pop just after the rising edge.
    task automatic cycle();
        logic [1:0] exp_rd, exp_wr, elig, pops;
        logic       exp_busy;
        @(negedge clk);
        exp_rd = 2'b00;
        exp_wr = 2'b00;
        if (!reset) begin
            model_reset();
            exp_busy = 1'b0;
        end else begin
            exp_busy = (m_left != 0);
            if (m_left != 0) begin
                m_left--;
                if (m_left == 0) begin
                    exp_wr[m_g] = 1'b1;
                    m_yout[m_g] = m_y;
                    m_xp[m_g]   = m_x;
                    m_yp[m_g]   = m_y;
                    m_rr        = 1 - m_g;
                end
            end else if (ifc.hist_clr) begin
                for (int c = 0; c < 2; c++) begin
                    m_xp[c] = 0; m_yp[c] = 0;
                end
            end else begin
                elig = ~ifc.x_in_empty & ~ifc.y_out_full;
                if (elig != 2'b00) begin
                    m_g = (elig == 2'b11) ? m_rr : (elig[1] ? 1 : 0);
                    exp_rd[m_g] = 1'b1;
                    m_x    = inq[m_g][0];
                    m_y    = fmul(m_x, 178) + fmul(m_xp[m_g], 178) + fmul(m_yp[m_g], -666);
                    m_left = 4;
                    grant_log.push_back(m_g);
                end
            end
        end
        chk("rd_en",   32'(ifc.x_in_rd_en), 32'(exp_rd));
        chk("wr_en",   32'(ifc.y_out_wr_en), 32'(exp_wr));
        chk("busy",    32'(ifc.busy), 32'(exp_busy));
        chk("y_out0",  ifc.y_out[0], m_yout[0]);
        chk("y_out1",  ifc.y_out[1], m_yout[1]);
        chk("rd_while_full", 32'(ifc.x_in_rd_en & ifc.y_out_full), 32'd0);
        pops = ifc.x_in_rd_en;
        for (int c = 0; c < 2; c++)
            if (ifc.y_out_wr_en[c]) wr_log[c].push_back(ifc.y_out[c]);
        @(posedge clk);
        #1;
        for (int c = 0; c < 2; c++)
            if (pops[c] && inq[c].size() != 0) void'(inq[c].pop_front());
        refresh();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((inq[0].size() != 0 || inq[1].size() != 0 || m_left != 0) && n < 400) begin
            cycle();
            n++;
        end
        chk("drain_timeout", 32'(n >= 400), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        run(2);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int gpat;
        reset          = 1'b0;
        ifc.hist_clr   = 1'b0;
        ifc.y_out_full = 2'b00;
        model_reset();
        refresh();

        // reset state
        run(2);
        chk("reset_busy",  32'(ifc.busy), 32'd0);
        chk("reset_wr_en", 32'(ifc.y_out_wr_en), 32'd0);
        chk("reset_y0",    ifc.y_out[0], 32'd0);
        reset = 1'b1;

        // two samples on ch0 only
        clear_logs();
        push(0, 1024);
        push(0, 1024);
        drain();
        chk("t1_count0", 32'(wr_log[0].size()), 32'd2);
        chk("t1_count1", 32'(wr_log[1].size()), 32'd0);
        chk("t1_y0_a",   logv(0, 0), 32'd178);
        chk("t1_y0_b",   logv(0, 1), 32'd240);
        chk("t1_model",  m_yout[0], 32'd240);

        // both channels, three samples each, alternating grants
        do_reset();
        clear_logs();
        for (int i = 0; i < 3; i++) begin
            push(0, 1024);
            push(1, 1024);
        end
        drain();
        gpat = 0;
        for (int i = 0; i < grant_log.size() && i < 6; i++) gpat |= grant_log[i] << i;
        chk("t2_grants", 32'(gpat), 32'b101010);
        for (int c = 0; c < 2; c++) begin
            chk("t2_y_a", logv(c, 0), 32'd178);
            chk("t2_y_b", logv(c, 1), 32'd240);
            chk("t2_y_c", logv(c, 2), 32'd199);
        end

        // ch0 blocked by a full output FIFO
        clear_logs();
        ifc.y_out_full = 2'b01;
        push(0, 1024);
        push(1, 1024);
        run(15);
        chk("t3_ch1_served",  32'(wr_log[1].size()), 32'd1);
        chk("t3_ch0_blocked", 32'(wr_log[0].size()), 32'd0);
        chk("t3_ch0_pending", 32'(inq[0].size()), 32'd1);
        chk("t3_y1",          logv(1, 0), 32'd226);
        ifc.y_out_full = 2'b00;
        drain();
        chk("t3_y0", logv(0, 0), 32'd226);

        // reset during MAC1 aborts the sample and clears history
        do_reset();
        clear_logs();
        push(0, 1024);
        drain();
        chk("t4_first", logv(0, 0), 32'd178);
        clear_logs();
        push(0, 1024);
        run(2);
        reset = 1'b0;
        run(2);
        reset = 1'b1;
        run(6);
        chk("t4_no_write", 32'(wr_log[0].size()), 32'd0);
        push(0, 1024);
        drain();
        chk("t4_after", logv(0, 0), 32'd178);

        // history clear held in ARB: no pops, then fresh outputs on both channels
        push(1, 1024);
        drain();
        clear_logs();
        push(0, 1024);
        push(1, 1024);
        ifc.hist_clr = 1'b1;
        run(3);
        chk("t5_no_pop", 32'(inq[0].size() + inq[1].size()), 32'd2);
        ifc.hist_clr = 1'b0;
        drain();
        chk("t5_y0", logv(0, 0), 32'd178);
        chk("t5_y1", logv(1, 0), 32'd178);

        // large-magnitude samples on ch1, bit-exact against the model
        ifc.hist_clr = 1'b1;
        run(1);
        ifc.hist_clr = 1'b0;
        clear_logs();
        push(1, 32'h7FFF_FFFF);
        push(1, 32'h7FFF_FFFF);
        push(1, 32'h7FFF_FFFF);
        push(1, 32'h8000_0000);
        push(1, -1024);
        drain();
        chk("t6_count",  32'(wr_log[1].size()), 32'd5);
        chk("t6_first",  logv(1, 0), 32'd373293055);
        chk("t6_second", logv(1, 1), 32'd503799806);
        chk("t6_ch0_idle", 32'(wr_log[0].size()), 32'd0);
        run(3);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
